// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: takes operation requests on a valid/ready port and drives them
// to a fixed-latency clocked ALU as instruction words. It follows each instruction
// through the ALU pipeline, captures the result into an in-order FIFO and returns
// it on a valid/ready response port. Credits bound the number of outstanding
// operations so that the FIFO can never overflow.
module alu_issue_ctrl #(
   parameter int DATA_W      = 32,
   parameter int OP_W        = 3,
   parameter int ALU_LATENCY = 1,
   parameter int DEPTH       = 4
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [DATA_W-1:0]            req_a,
   input  logic [DATA_W-1:0]            req_b,
   input  logic [OP_W-1:0]              req_opcode,
   output logic                         iw_valid,
   output logic [DATA_W-1:0]            iw_a,
   output logic [DATA_W-1:0]            iw_b,
   output logic [OP_W-1:0]              iw_opcode,
   input  logic [DATA_W-1:0]            alu_result,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [DATA_W-1:0]            rsp_result,
   output logic [$clog2(DEPTH+1)-1:0]   outstanding
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);

   logic                 req_fire;
   logic                 rsp_fire;
   logic                 wr_en;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic [ALU_LATENCY:0] inflight;
   logic [PTR_W:0]       wr_ptr;
   logic [PTR_W:0]       rd_ptr;
   logic [DATA_W-1:0]    fifo_mem [DEPTH];

   // Credit check uses registered state only; held low while reset is asserted.
   assign req_ready  = reset_n && (outstanding < CNT_W'(DEPTH));
   assign req_fire   = req_valid && req_ready;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign rsp_valid  = !fifo_empty;
   assign rsp_fire   = rsp_valid && rsp_ready;
   assign rsp_result = rsp_valid ? fifo_mem[rd_ptr[PTR_W-1:0]] : '0;

   // The oldest stage of the in-flight tracker marks the cycle the ALU result is valid.
   assign wr_en      = inflight[ALU_LATENCY];

   // Register an accepted request as the instruction word; fields hold otherwise.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         iw_valid  <= 1'b0;
         iw_a      <= '0;
         iw_b      <= '0;
         iw_opcode <= '0;
      end else begin
         iw_valid <= req_fire;
         if (req_fire) begin
            iw_a      <= req_a;
            iw_b      <= req_b;
            iw_opcode <= req_opcode;
         end
      end
   end

   // Shift the issue marker along the ALU pipeline; stage 0 mirrors iw_valid.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         inflight <= '0;
      end else begin
         inflight <= {inflight[ALU_LATENCY-1:0], req_fire};
      end
   end

   // Capture the ALU result into the FIFO storage when its instruction completes.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         fifo_mem[wr_ptr[PTR_W-1:0]] <= alu_result;
      end
   end

   // Advance the FIFO pointers on result capture and on response handshake.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         end
         if (rsp_fire) begin
            rd_ptr <= rd_ptr + (PTR_W+1)'(1);
         end
      end
   end

   // Count operations from request handshake until response handshake.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         outstanding <= '0;
      end else begin
         case ({req_fire, rsp_fire})
            2'b10:   outstanding <= outstanding + CNT_W'(1);
            2'b01:   outstanding <= outstanding - CNT_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   // Credit gating must make a write into a full FIFO impossible.
   assert property (@(posedge clock) disable iff (!reset_n) !(wr_en && fifo_full));

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl with a behavioural
// single-cycle ALU. Expected results are queued when a request handshake is seen
// and compared in order when a response handshake is seen.
module tb_alu_issue_ctrl;

   localparam int DATA_W      = 32;
   localparam int OP_W        = 3;
   localparam int ALU_LATENCY = 1;
   localparam int DEPTH       = 4;
   localparam int CNT_W       = $clog2(DEPTH + 1);

   localparam logic [OP_W-1:0] OP_ADD = 3'd0;
   localparam logic [OP_W-1:0] OP_SUB = 3'd1;
   localparam logic [OP_W-1:0] OP_AND = 3'd2;
   localparam logic [OP_W-1:0] OP_OR  = 3'd3;
   localparam logic [OP_W-1:0] OP_XOR = 3'd4;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              req_valid;
   logic              req_ready;
   logic [DATA_W-1:0] req_a;
   logic [DATA_W-1:0] req_b;
   logic [OP_W-1:0]   req_opcode;
   logic              iw_valid;
   logic [DATA_W-1:0] iw_a;
   logic [DATA_W-1:0] iw_b;
   logic [OP_W-1:0]   iw_opcode;
   logic [DATA_W-1:0] alu_result;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_result;
   logic [CNT_W-1:0]  outstanding;

   int total_checks = 0;
   int bad_checks   = 0;
   int rsp_count    = 0;

   logic [DATA_W-1:0] sb_q [$];
   logic              iw_pend = 1'b0;
   logic [DATA_W-1:0] iw_exp_a;
   logic [DATA_W-1:0] iw_exp_b;
   logic [OP_W-1:0]   iw_exp_op;

   alu_issue_ctrl #(
      .DATA_W(DATA_W), .OP_W(OP_W), .ALU_LATENCY(ALU_LATENCY), .DEPTH(DEPTH)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
      .iw_valid(iw_valid), .iw_a(iw_a), .iw_b(iw_b), .iw_opcode(iw_opcode),
      .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .outstanding(outstanding)
   );

   always #5 clock = ~clock;

   // Reference behaviour of the ALU operations
   function automatic logic [DATA_W-1:0] alu_model(input logic [OP_W-1:0] op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         default: return '0;
      endcase
   endfunction

   // Behavioural ALU: samples the instruction word on a clock edge, result valid one edge later
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) alu_result <= '0;
      else if (iw_valid) alu_result <= alu_model(iw_opcode, iw_a, iw_b);
   end

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total_checks++;
      if (got !== exp) begin
         bad_checks++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // All outputs must be zero while reset is held
   task automatic checkResetState();
      checkOutput("rst_iw_valid", iw_valid, 1'b0);
      checkOutput("rst_iw_a", iw_a, '0);
      checkOutput("rst_iw_b", iw_b, '0);
      checkOutput("rst_iw_opcode", iw_opcode, '0);
      checkOutput("rst_rsp_valid", rsp_valid, 1'b0);
      checkOutput("rst_rsp_result", rsp_result, '0);
      checkOutput("rst_outstanding", outstanding, '0);
      checkOutput("rst_req_ready", req_ready, 1'b0);
   endtask

   // Present one request and hold it until accepted; returns 1 time unit after the accepting edge
   task automatic applyStimulus(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                input logic [OP_W-1:0] op);
      bit accepted = 1'b0;
      req_valid  = 1'b1;
      req_a      = a;
      req_b      = b;
      req_opcode = op;
      for (int i = 0; i < 50 && !accepted; i++) begin
         @(negedge clock);
         accepted = req_ready;
      end
      if (!accepted) checkOutput("req_accept_timeout", req_ready, 1'b1);
      @(posedge clock); #1;
      req_valid = 1'b0;
   endtask

   // Monitor on the falling edge: checks instruction words, pushes and pops the scoreboard
   always @(negedge clock) begin
      if (!reset_n) begin
         sb_q.delete();
         iw_pend = 1'b0;
      end else begin
         checkOutput("iw_valid", iw_valid, iw_pend);
         if (iw_pend) begin
            checkOutput("iw_a", iw_a, iw_exp_a);
            checkOutput("iw_b", iw_b, iw_exp_b);
            checkOutput("iw_opcode", iw_opcode, iw_exp_op);
         end
         iw_pend = req_valid && req_ready;
         if (iw_pend) begin
            iw_exp_a  = req_a;
            iw_exp_b  = req_b;
            iw_exp_op = req_opcode;
            sb_q.push_back(alu_model(req_opcode, req_a, req_b));
         end
         if (rsp_valid && rsp_ready) begin
            rsp_count++;
            if (sb_q.size() == 0) checkOutput("rsp_unexpected", rsp_valid, 1'b0);
            else checkOutput("rsp_result", rsp_result, sb_q.pop_front());
         end
      end
   end

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence of directed scenarios
   initial begin
      int rsp_before;
      reset_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_opcode = '0; rsp_ready = 1'b0;

      // Reset state and release
      #12;
      checkResetState();
      #5 reset_n = 1'b1;
      @(posedge clock); #1;
      checkOutput("rel_req_ready", req_ready, 1'b1);
      checkOutput("rel_outstanding", outstanding, '0);

      // Single operation with exact cycle timing
      rsp_ready = 1'b1;
      applyStimulus(32'd5, 32'd7, OP_ADD);
      checkOutput("single_iw_valid", iw_valid, 1'b1);
      checkOutput("single_iw_a", iw_a, 32'd5);
      checkOutput("single_iw_b", iw_b, 32'd7);
      checkOutput("single_iw_op", iw_opcode, OP_ADD);
      checkOutput("single_outst1", outstanding, 1);
      checkOutput("single_rsp_early", rsp_valid, 1'b0);
      @(posedge clock); #1;
      checkOutput("single_iw_drop", iw_valid, 1'b0);
      checkOutput("single_iw_hold", iw_a, 32'd5);
      checkOutput("single_rsp_early2", rsp_valid, 1'b0);
      @(posedge clock); #1;
      checkOutput("single_rsp_valid", rsp_valid, 1'b1);
      checkOutput("single_rsp_value", rsp_result, 32'd12);
      @(posedge clock); #1;
      checkOutput("single_outst0", outstanding, '0);

      // Backpressure fill: four accepted, fifth waits for credit
      rsp_ready = 1'b0;
      fork
         begin
            for (int i = 1; i <= 5; i++) applyStimulus(DATA_W'(i), DATA_W'(i), OP_ADD);
         end
         begin
            repeat (8) @(posedge clock); #1;
            checkOutput("fill_outst", outstanding, DEPTH);
            checkOutput("fill_ready", req_ready, 1'b0);
            checkOutput("fill_head", rsp_result, 32'd2);
            rsp_ready = 1'b1;
         end
      join
      repeat (6) @(posedge clock); #1;
      checkOutput("fill_outst0", outstanding, '0);
      checkOutput("fill_sb_empty", sb_q.size(), 0);

      // Hold stability under response backpressure
      rsp_ready = 1'b0;
      applyStimulus(32'd10, 32'd1, OP_ADD);
      applyStimulus(32'd20, 32'd5, OP_SUB);
      repeat (3) @(posedge clock); #1;
      for (int i = 0; i < 5; i++) begin
         checkOutput("hold_valid", rsp_valid, 1'b1);
         checkOutput("hold_result", rsp_result, 32'd11);
         @(posedge clock); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
      checkOutput("hold_next", rsp_result, 32'd15);
      checkOutput("hold_outst", outstanding, 1);
      repeat (2) @(posedge clock); #1;
      checkOutput("hold_still", rsp_result, 32'd15);
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      checkOutput("hold_empty", rsp_valid, 1'b0);

      // Simultaneous request and response handshakes at DEPTH-1
      rsp_ready = 1'b0;
      applyStimulus(32'hF0F0, 32'hFF00, OP_AND);
      applyStimulus(32'h0F, 32'hF0, OP_OR);
      applyStimulus(32'hAA, 32'hFF, OP_XOR);
      repeat (3) @(posedge clock); #1;
      checkOutput("sim_pre_outst", outstanding, DEPTH - 1);
      req_valid = 1'b1; req_a = 32'd9; req_b = 32'd9; req_opcode = OP_ADD;
      rsp_ready = 1'b1;
      checkOutput("sim_pre_ready", req_ready, 1'b1);
      checkOutput("sim_pre_rsp", rsp_valid, 1'b1);
      @(posedge clock); #1;
      req_valid = 1'b0;
      checkOutput("sim_outst", outstanding, DEPTH - 1);
      checkOutput("sim_ready", req_ready, 1'b1);
      repeat (6) @(posedge clock); #1;
      checkOutput("sim_outst0", outstanding, '0);
      checkOutput("sim_sb_empty", sb_q.size(), 0);

      // Reset mid-flight discards work; a new operation then completes normally
      applyStimulus(32'd1, 32'd2, OP_ADD);
      applyStimulus(32'd3, 32'd4, OP_ADD);
      #2 reset_n = 1'b0;
      #1 checkResetState();
      @(negedge clock);
      #2 reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clock); #1;
         checkOutput("rstmid_no_rsp", rsp_valid, 1'b0);
      end
      checkOutput("rstmid_outst", outstanding, '0);
      rsp_before = rsp_count;
      applyStimulus(32'd7, 32'd3, OP_SUB);
      repeat (4) @(posedge clock); #1;
      checkOutput("rstmid_new_rsp", rsp_count - rsp_before, 1);
      checkOutput("rstmid_new_outst", outstanding, '0);
      checkOutput("rstmid_sb_empty", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU instruction interface. Accepts operation requests (a, b, opcode) on a valid/ready port and drives them to the clocked ALU as instruction words.
- Tracks each instruction through the fixed ALU latency, captures the result and returns it in order on a valid/ready response port.
- Sits between a sequencer or test harness and the ALU. It replaces hand-driven instruction words.

Parameters:
- DATA_W, 32, operand and result width.
- OP_W, 3, opcode width, matching the opcode enum of the instruction word.
- ALU_LATENCY, 1, clock edges from the ALU sampling the instruction word to its result being valid (range 1..4).
- DEPTH, 4, maximum outstanding operations (in flight plus buffered). Power of two, minimum 2.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid at a rising edge.
- req_a  in  DATA_W  operand a.
- req_b  in  DATA_W  operand b.
- req_opcode  in  OP_W  operation.
- iw_valid  out  1  instruction word valid this cycle.
- iw_a  out  DATA_W  instruction word field a.
- iw_b  out  DATA_W  instruction word field b.
- iw_opcode  out  OP_W  instruction word field opcode.
- alu_result  in  DATA_W  ALU result bus.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result at a rising edge when high together with rsp_valid.
- rsp_result  out  DATA_W  oldest unconsumed result.
- outstanding  out  $clog2(DEPTH+1)  current outstanding count.

Behaviour:
- Reset (reset_n low, asynchronous): all of the following are 0:
  - iw_valid, iw_a, iw_b, iw_opcode;
  - rsp_valid, rsp_result;
  - outstanding;
  - the in-flight shift register and the FIFO pointers.
- req_ready is 0 while in reset.
- Reset mid-operation discards all in-flight and buffered results. No response is produced for them.
- Acceptance:
  - req_ready = (outstanding < DEPTH). It is combinational from registered state only and never depends on req_valid.
  - On an accepting edge E, iw_a/iw_b/iw_opcode register the request fields and iw_valid=1 for the cycle after E.
  - Without an accept, iw_valid=0 and the iw fields hold their last values.
- In-flight tracking:
  - A valid shift register of length ALU_LATENCY+1 records iw_valid.
  - An instruction driven after edge E is sampled by the ALU at E+1. Its result is written into the result FIFO at edge E+ALU_LATENCY+1.
- Latency and throughput:
  - rsp_valid first rises ALU_LATENCY+1 edges after the accepting edge (2 cycles at default).
  - Throughput is one operation per cycle when not backpressured.
- Result FIFO:
  - DEPTH entries, in-order.
  - rsp_valid = FIFO non-empty. rsp_result = head entry.
  - rsp_result and rsp_valid stay stable while rsp_valid && !rsp_ready.
  - No bypass: a result is never presented in the cycle it is written.
- outstanding:
  - +1 on a request handshake, −1 on a response handshake, unchanged when both occur on the same edge.
  - Because of credit gating the FIFO cannot overflow. A write to a full FIFO is an assertion failure.
- Full boundary: at outstanding==DEPTH, req_ready=0. A response handshake on edge E raises req_ready after E. There is no same-cycle pass-through of credit.
- Empty boundary: rsp_ready with rsp_valid=0 has no effect. outstanding never underflows.
- Arithmetic: the block does not modify data. alu_result is captured bit-exact at full DATA_W.

Test Plan:
- Reset: assert reset_n=0 mid-clock -> all outputs 0 immediately. req_ready=0. After release, req_ready=1 and outstanding=0.
- Single op: req a=5, b=7, opcode=ADD, rsp_ready=1 -> iw_valid for one cycle with a=5, b=7, ADD. rsp_valid rises 2 edges after accept with rsp_result=12. outstanding returns to 0.
- Backpressure fill: rsp_ready=0, issue ADD (1,1),(2,2),(3,3),(4,4),(5,5) back-to-back -> first four accepted, req_ready=0 after 4th, outstanding=4. Raise rsp_ready -> results 2,4,6,8 in order, then 5th accepted, result 10.
- Hold stability: rsp_ready=0 for 5 cycles with rsp_valid=1 -> rsp_result constant. Release -> single handshake, no duplicate or lost entry.
- Simultaneous: at outstanding=DEPTH-1, request and response handshakes on the same edge -> outstanding unchanged, req_ready stays 1.
- Reset mid-flight: two ops accepted, reset_n pulsed low before any result returns -> no rsp_valid afterwards, outstanding=0, a new op completes normally.
